// File: rtl/randnum.sv
// Range-reduced pseudo-random number source built on a 16-bit Fibonacci LFSR.
// Defining RANDNUM_STEP_COUNT_EN adds a saturating step_count output.
module randnum #(
    parameter int unsigned WIDTH   = 9,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MAX_VAL = 479
) (
    input  logic             CLK,
    input  logic             RST_BTN,
    input  logic             en,
    input  logic             load,
    input  logic [15:0]      seed_in,
    output logic [WIDTH-1:0] random,
    output logic             valid,
`ifdef RANDNUM_STEP_COUNT_EN
    output logic [15:0]      step_count,
`endif
    output logic [15:0]      lfsr_state
);

    // An all-zero state would lock the LFSR, so zero seeds are promoted to 1.
    localparam logic [15:0]      SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] WRAP_SUB  = WIDTH'(MAX_VAL + 1);

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic logic [WIDTH-1:0] range_reduce(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ({1'b0, v} <= MAX_EXT) begin
            r = v;
        end else begin
            r = v - WRAP_SUB;
        end
        return r;
    endfunction

    logic [15:0]      state_r;
    logic [WIDTH-1:0] random_r;
    logic             valid_r;
    logic [15:0]      next_state_s;
    logic [15:0]      load_state_s;
    logic [WIDTH-1:0] next_random_s;

    // Next LFSR step, its reduced output, and the sanitised load value.
    always_comb begin
        next_state_s  = lfsr_next(state_r);
        next_random_s = range_reduce(next_state_s[WIDTH-1:0]);
        if (seed_in == 16'h0000) begin
            load_state_s = 16'h0001;
        end else begin
            load_state_s = seed_in;
        end
    end

    // Main state: load wins over en; otherwise everything holds.
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_r  <= SEED_EFF;
            random_r <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else if (load) begin
            state_r  <= load_state_s;
            valid_r  <= 1'b0;
        end else if (en) begin
            state_r  <= next_state_s;
            random_r <= next_random_s;
            valid_r  <= 1'b1;
        end
    end

`ifdef RANDNUM_STEP_COUNT_EN
    logic [15:0] step_count_r;

    // Saturating count of LFSR steps since the last reset or load.
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            step_count_r <= 16'h0000;
        end else if (load) begin
            step_count_r <= 16'h0000;
        end else if (en && (step_count_r != 16'hFFFF)) begin
            step_count_r <= step_count_r + 16'h0001;
        end
    end

    assign step_count = step_count_r;
`endif

    assign random     = random_r;
    assign valid      = valid_r;
    assign lfsr_state = state_r;

endmodule

// File: tb/tb_randnum.sv
// Directed bench for randnum with hand-computed LFSR values and a full-period run.
// Also checks step_count when RANDNUM_STEP_COUNT_EN is defined.
module tb_randnum;

    logic        CLK;
    logic        RST_BTN;
    logic        en;
    logic        load;
    logic [15:0] seed_in;
    logic [8:0]  random;
    logic        valid;
    logic [15:0] lfsr_state;
`ifdef RANDNUM_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    int checks_r;
    int errors_r;

    randnum dut (
        .CLK        (CLK),
        .RST_BTN    (RST_BTN),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .random     (random),
        .valid      (valid),
`ifdef RANDNUM_STEP_COUNT_EN
        .step_count (step_count),
`endif
        .lfsr_state (lfsr_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_r++;
        if (actual !== expected) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] st, input logic [8:0] rn, input logic vl);
        check_val({tag, "_state"},  32'(lfsr_state), 32'(st));
        check_val({tag, "_random"}, 32'(random),     32'(rn));
        check_val({tag, "_valid"},  32'(valid),      32'(vl));
    endtask

    int early_r;
    int zero_r;
    int range_r;

    initial begin
        checks_r = 0;
        errors_r = 0;
        RST_BTN  = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        seed_in  = 16'h0000;
        #12;
        check_out("reset", 16'hACE1, 9'd0, 1'b0);
`ifdef RANDNUM_STEP_COUNT_EN
        check_val("reset_count", 32'(step_count), 32'h0);
`endif
        @(negedge CLK);
        RST_BTN = 1'b1;

        en = 1'b1;
        tick();
        check_out("step1", 16'h5670, 9'd112, 1'b1);
        tick();
        check_out("step2", 16'hAB38, 9'd312, 1'b1);

        en      = 1'b0;
        load    = 1'b1;
        seed_in = 16'h03E0;
        tick();
        check_out("load3e0", 16'h03E0, 9'd312, 1'b0);
        load = 1'b0;
        en   = 1'b1;
        tick();
        check_out("wrap", 16'h81F0, 9'd16, 1'b1);

        load    = 1'b1;
        seed_in = 16'h1234;
        tick();
        check_out("load_pri", 16'h1234, 9'd16, 1'b0);
        load = 1'b0;
        en   = 1'b0;
        tick();
        tick();
        tick();
        check_out("hold", 16'h1234, 9'd16, 1'b0);

        load    = 1'b1;
        seed_in = 16'h0000;
        tick();
        check_out("load0", 16'h0001, 9'd16, 1'b0);
        load = 1'b0;
        en   = 1'b1;
        tick();
        check_out("from1", 16'h8000, 9'd0, 1'b1);
        tick();
        tick();
        check_out("from1b", 16'h2000, 9'd0, 1'b1);

        // Asynchronous reset between edges.
        #3;
        RST_BTN = 1'b0;
        #1;
        check_out("async_rst", 16'hACE1, 9'd0, 1'b0);
        @(negedge CLK);
        RST_BTN = 1'b1;

        early_r = 0;
        zero_r  = 0;
        range_r = 0;
        en      = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (i < 65535 && lfsr_state == 16'hACE1) early_r++;
            if (lfsr_state == 16'h0000) zero_r++;
            if (random > 9'd479) range_r++;
        end
        check_out("period", 16'hACE1, 9'd225, 1'b1);
        check_val("early_return", 32'(early_r), 32'd0);
        check_val("zero_state",   32'(zero_r),  32'd0);
        check_val("out_of_range", 32'(range_r), 32'd0);
`ifdef RANDNUM_STEP_COUNT_EN
        check_val("count_full", 32'(step_count), 32'hFFFF);
`endif
        tick();
        check_out("wrap_step", 16'h5670, 9'd112, 1'b1);
`ifdef RANDNUM_STEP_COUNT_EN
        check_val("count_sat", 32'(step_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
